// File: rtl/four_to_one_rr_arbiter_pkg.sv
// Shared types and constants for the four-channel round-robin arbiter.
package four_to_one_rr_arbiter_pkg;

  localparam int NUM_CH = 4;

  typedef logic [1:0] ch_idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic logic [NUM_CH-1:0] ch_onehot(ch_idx_t idx);
    logic [NUM_CH-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/four_to_one_rr_arbiter_if.sv
// Request/data/handshake bundle between requesters and the arbiter.
interface four_to_one_rr_arbiter_if
  import four_to_one_rr_arbiter_pkg::*;
#(
  parameter int W = 1
);

  logic [NUM_CH-1:0] req;
  logic [W-1:0]      a;
  logic [W-1:0]      b;
  logic [W-1:0]      c;
  logic [W-1:0]      d;
  logic              ready;
  ch_idx_t           s;
  logic [W-1:0]      y;
  logic              valid;
  logic [NUM_CH-1:0] gnt;

  modport master (
    output req, a, b, c, d, ready,
    input  s, y, valid, gnt
  );

  modport slave (
    input  req, a, b, c, d, ready,
    output s, y, valid, gnt
  );

endinterface

// File: rtl/rr_next_pick.sv
// Combinational round-robin pick: first set req bit searching from last+1 around to last.
module rr_next_pick
  import four_to_one_rr_arbiter_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  ch_idx_t           last,
  output ch_idx_t           pick,
  output logic              any
);

  // Walk the search order backwards so the closest candidate to last+1 wins.
  always_comb begin
    pick = last;
    for (int k = NUM_CH; k >= 1; k--) begin
      if (req[last + ch_idx_t'(k)]) pick = last + ch_idx_t'(k);
    end
  end

  assign any = |req;

endmodule

// File: rtl/four_to_one_rr_arbiter.sv
// Four-input round-robin arbiter with registered select/data and ready backpressure.
//   state | meaning
//   IDLE  | no transfer held, valid=0, waiting for any request
//   HOLD  | s/y hold a granted transfer until ready accepts it
module four_to_one_rr_arbiter
  import four_to_one_rr_arbiter_pkg::*;
#(
  parameter int W = 1
)(
  input  logic                      clk,
  input  logic                      rst_n,
  four_to_one_rr_arbiter_if.slave   bus
);

  state_t            state;
  state_t            state_next;
  ch_idx_t           s_q;
  ch_idx_t           s_next;
  ch_idx_t           last;
  ch_idx_t           last_next;
  ch_idx_t           pick;
  logic [W-1:0]      y_q;
  logic [W-1:0]      y_next;
  logic [W-1:0]      y_pick;
  logic [NUM_CH-1:0] gnt;
  logic              any;
  logic              accept;
  logic              load;

  rr_next_pick u_pick (
    .req  (bus.req),
    .last (last_next),
    .pick (pick),
    .any  (any)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      s_q   <= '0;
      y_q   <= '0;
      last  <= 2'd3;
    end else begin
      state <= state_next;
      s_q   <= s_next;
      y_q   <= y_next;
      last  <= last_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any) state_next = HOLD;
      HOLD:    if (bus.ready && !any) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    case (pick)
      2'd0:    y_pick = bus.a;
      2'd1:    y_pick = bus.b;
      2'd2:    y_pick = bus.c;
      default: y_pick = bus.d;
    endcase
  end

  // The pick in an accept cycle must already see the channel being accepted as last.
  always_comb begin
    accept    = (state == HOLD) && bus.ready;
    last_next = accept ? s_q : last;
    load      = any && ((state == IDLE) || accept);
    s_next    = load ? pick : s_q;
    y_next    = load ? y_pick : y_q;
    gnt       = (accept && rst_n) ? ch_onehot(s_q) : '0;
  end

  assign bus.s     = s_q;
  assign bus.y     = y_q;
  assign bus.valid = (state == HOLD);
  assign bus.gnt   = gnt;

endmodule

// File: tb/tb_four_to_one_rr_arbiter.sv
// Self-checking bench for four_to_one_rr_arbiter: directed scenarios plus random traffic vs a reference model.
module tb_four_to_one_rr_arbiter;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  four_to_one_rr_arbiter_if #(.W(W)) bus ();

  four_to_one_rr_arbiter #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // reference model state
  bit           m_hold = 1'b0;
  logic [1:0]   m_s    = 2'd0;
  logic [1:0]   m_last = 2'd3;
  logic [W-1:0] m_y    = '0;
  logic [3:0]   g_obs;
  logic [3:0]   g_exp;

  function automatic logic [1:0] ref_pick(logic [3:0] r, logic [1:0] l);
    for (int k = 1; k <= 4; k++) begin
      int idx;
      idx = (int'(l) + k) % 4;
      if (r[idx]) return 2'(idx);
    end
    return l;
  endfunction

  function automatic logic [W-1:0] data_of(logic [1:0] idx);
    case (idx)
      2'd0:    return bus.a;
      2'd1:    return bus.b;
      2'd2:    return bus.c;
      default: return bus.d;
    endcase
  endfunction

  // One clock: sample gnt mid-cycle, advance the model at the edge, settle past it.
  task automatic clock_cycle();
    logic [3:0] r;
    bit         acc;
    @(negedge clk);
    g_obs = bus.gnt;
    g_exp = (m_hold && bus.ready && rst_n) ? 4'(1 << m_s) : 4'b0;
    @(posedge clk);
    r = bus.req;
    if (!rst_n) begin
      m_hold = 1'b0; m_s = 2'd0; m_y = '0; m_last = 2'd3;
    end else begin
      acc = m_hold && bus.ready;
      if (acc) m_last = m_s;
      if (!m_hold || acc) begin
        if (r != 4'b0) begin
          m_s    = ref_pick(r, m_last);
          m_y    = data_of(m_s);
          m_hold = 1'b1;
        end else begin
          m_hold = 1'b0;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; bus.req = 4'b0; bus.ready = 1'b0;
    clock_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.req = 4'b0; bus.ready = 1'b0;
    clock_cycle();
    clock_cycle();
    n_total++;
    if ({bus.s, bus.y, bus.valid, bus.gnt} !== '0)
      $display("FAIL reset_idle: s=%0d y=%0h valid=%0b gnt=%b want all 0", bus.s, bus.y, bus.valid, bus.gnt);
    else n_pass++;
    bus.req = 4'b1111; bus.ready = 1'b1; bus.a = 4'hf;
    clock_cycle();
    n_total++;
    if ({bus.s, bus.y, bus.valid, bus.gnt, g_obs} !== '0)
      $display("FAIL reset_hold_busy: s=%0d y=%0h valid=%0b gnt=%b want all 0", bus.s, bus.y, bus.valid, g_obs);
    else n_pass++;
  endtask

  task automatic test_single();
    do_reset();
    bus.req = 4'b0100; bus.a = 4'h0; bus.b = 4'h0; bus.c = 4'h1; bus.d = 4'h0; bus.ready = 1'b1;
    clock_cycle();
    n_total++;
    if (bus.s !== 2'd2 || bus.y !== 4'h1 || bus.valid !== 1'b1)
      $display("FAIL single_first: s=%0d y=%0h valid=%0b want 2 1 1", bus.s, bus.y, bus.valid);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      clock_cycle();
      n_total++;
      if (g_obs !== 4'b0100 || bus.s !== 2'd2 || bus.valid !== 1'b1)
        $display("FAIL single_regrant: gnt=%b s=%0d valid=%0b want 0100 2 1", g_obs, bus.s, bus.valid);
      else n_pass++;
    end
  endtask

  task automatic test_contention();
    logic [3:0] ge;
    do_reset();
    bus.req = 4'b1111; bus.ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      clock_cycle();
      ge = (i == 0) ? 4'b0 : 4'(1 << ((i - 1) % 4));
      n_total++;
      if (bus.s !== 2'(i % 4) || g_obs !== ge)
        $display("FAIL contention_%0d: s=%0d gnt=%b want %0d %b", i, bus.s, g_obs, i % 4, ge);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.req = 4'b0011; bus.a = 4'h1; bus.b = 4'h2; bus.ready = 1'b0;
    clock_cycle();
    for (int i = 0; i < 5; i++) begin
      bus.req = 4'($urandom); bus.a = 4'($urandom);
      clock_cycle();
      n_total++;
      if (bus.s !== 2'd0 || bus.y !== 4'h1 || bus.valid !== 1'b1 || g_obs !== 4'b0)
        $display("FAIL backpressure_hold: s=%0d y=%0h valid=%0b gnt=%b want 0 1 1 0000", bus.s, bus.y, bus.valid, g_obs);
      else n_pass++;
    end
    bus.req = 4'b0011; bus.a = 4'h1; bus.ready = 1'b1;
    clock_cycle();
    n_total++;
    if (g_obs !== 4'b0001 || bus.s !== 2'd1 || bus.y !== 4'h2)
      $display("FAIL backpressure_release: gnt=%b s=%0d y=%0h want 0001 1 2", g_obs, bus.s, bus.y);
    else n_pass++;
  endtask

  task automatic test_late_arrival();
    do_reset();
    bus.req = 4'b0010; bus.ready = 1'b0;
    clock_cycle();
    bus.req = 4'b1000; bus.ready = 1'b1;
    clock_cycle();
    n_total++;
    if (g_obs !== 4'b0010 || bus.s !== 2'd3 || bus.valid !== 1'b1)
      $display("FAIL late_arrival: gnt=%b s=%0d valid=%0b want 0010 3 1", g_obs, bus.s, bus.valid);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    do_reset();
    bus.req = 4'b0100; bus.ready = 1'b0;
    clock_cycle();
    rst_n = 1'b0;
    clock_cycle();
    n_total++;
    if (bus.valid !== 1'b0 || bus.s !== 2'd0 || g_obs !== 4'b0 || bus.gnt !== 4'b0)
      $display("FAIL mid_reset_drop: valid=%0b s=%0d gnt=%b want 0 0 0000", bus.valid, bus.s, g_obs);
    else n_pass++;
    rst_n = 1'b1; bus.req = 4'b1111;
    clock_cycle();
    n_total++;
    if (bus.s !== 2'd0 || bus.valid !== 1'b1 || g_obs !== 4'b0)
      $display("FAIL mid_reset_first: s=%0d valid=%0b gnt=%b want 0 1 0000", bus.s, bus.valid, g_obs);
    else n_pass++;
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 400; i++) begin
      bus.req   = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom);
      bus.a     = 4'($urandom); bus.b = 4'($urandom);
      bus.c     = 4'($urandom); bus.d = 4'($urandom);
      bus.ready = ($urandom_range(0, 2) != 0);
      rst_n     = ($urandom_range(0, 49) != 0);
      clock_cycle();
      n_total++;
      if (g_obs !== g_exp || bus.s !== m_s || bus.y !== m_y || bus.valid !== m_hold) begin
        if (errs < 10)
          $display("FAIL random_%0d: gnt=%b s=%0d y=%0h valid=%0b want %b %0d %0h %0b",
                   i, g_obs, bus.s, bus.y, bus.valid, g_exp, m_s, m_y, m_hold);
        errs++;
      end else n_pass++;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    bus.req = 4'b0; bus.a = '0; bus.b = '0; bus.c = '0; bus.d = '0; bus.ready = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_late_arrival();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/four_to_one_rr_arbiter.md
FOUR_TO_ONE_RR_ARBITER -- requirements
Module: four_to_one_rr_arbiter

Interface
REQ-001 Parameter: W, default 1, width of each data channel and of y.
REQ-002 The block SHALL use one clock and a synchronous, active-low reset, named clk and rst_n.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  synchronous active-low reset, sampled on clk rising edge.
REQ-005 req  input  4  per-channel request; bit i = channel i (a=0, b=1, c=2, d=3).
REQ-006 a, b, c, d  input  W each  channel data.
REQ-007 ready  input  1  downstream accepts the current transfer.
REQ-008 s  output  2  registered select index of the granted channel; drives the downstream 4:1 mux select.
REQ-009 y  output  W  registered data of the granted channel.
REQ-010 valid  output  1  s and y hold a granted transfer.
REQ-011 gnt  output  4  one-hot, one-cycle pulse on acceptance; bit s is set.

Function
REQ-012 FSM states SHALL be IDLE and HOLD.
REQ-013 IDLE, req==0: stay in IDLE with valid=0; s and y keep their last values.
REQ-014 IDLE, req!=0: at the next edge, pick a channel, load s=pick and y=data[pick], set valid=1, and go to HOLD. Latency from req to valid is 1 cycle.
REQ-015 Pick rule: search for the first set req bit in the order (last+1, last+2, last+3, last) mod 4, where last is the index of the most recently accepted channel.
REQ-016 HOLD, valid && !ready: s, y and valid SHALL stay stable. Changes on req and data SHALL be ignored.
REQ-017 HOLD, ready=1 (accept cycle), all of these at the same edge:
  - gnt[s] pulses for exactly that cycle.
  - last=s.
  - If req!=0 in that cycle, pick again using the updated last, reload s/y, keep valid=1, and stay in HOLD (back-to-back transfers, no bubble).
  - Otherwise set valid=0 and go to IDLE.
REQ-018 req and data are sampled only at grant. A requester may drop req after grant without affecting the held transfer.
REQ-019 Under continuous requests on all four channels, the grant order SHALL be 0,1,2,3,0,... with one grant per accepting cycle.
REQ-020 A single requester SHALL be re-granted on every accept (no forced idle).
REQ-021 A req bit that rises in the same cycle as an accept SHALL take part in that cycle's pick.
REQ-022 gnt SHALL be 0 in every cycle that is not an accept cycle.

Reset
REQ-023 With rst_n=0 at an edge:
  - state=IDLE
  - s=0, y=0, valid=0, gnt=0
  - last=3, so channel 0 has first priority.
REQ-024 Reset in the middle of HOLD SHALL drop the pending transfer without a gnt pulse. The first grant after reset follows REQ-023 priority.
REQ-025 Outputs SHALL reach reset values at the first edge with rst_n=0 and stay there while rst_n=0, regardless of req and ready.

Structure
REQ-026 A shared package SHALL hold:
  - the state enum (IDLE, HOLD)
  - the localparam NUM_CH=4
  - the 2-bit channel index typedef.
REQ-027 The rotate-and-priority pick SHALL be a combinational sub-module, rr_next_pick, with inputs req[3:0] and last[1:0] and outputs pick[1:0] and any.
REQ-028 The y data selection SHALL be a case on pick. No latches; all state in one clocked process.

Verification
REQ-029 Reset then idle: rst_n=0 for 2 cycles, req=0 -> s=0, y=0, valid=0, gnt=0.
REQ-030 Single request: req=4'b0100, c=1, ready=1 -> one cycle later s=2, y=1, valid=1; gnt=4'b0100 on each accept; s stays 2.
REQ-031 Full contention: req=4'b1111 held, ready=1 -> s sequence 0,1,2,3,0; gnt sequence 0001,0010,0100,1000.
REQ-032 Backpressure: req=4'b0011 with a=1, ready=0 for 5 cycles -> s=0, y=1 stable, gnt=0. Then ready=1 -> gnt=0001, next s=1.
REQ-033 Late arrival: granted s=1, req drops to 4'b1000 in the accept cycle -> next s=3 with no idle cycle.
REQ-034 Mid-transfer reset: valid=1, s=2, ready=0, rst_n=0 for 1 cycle -> valid=0, gnt never pulsed. Then req=4'b1111 -> first s=0.
